// File: rtl/merge_sort_pkg.sv
// Shared types and helpers for the merge-sort sequencer: FSM encoding,
// parameter defaults, a log2 helper and the closed-form sort latency.
package merge_sort_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((32'd1 << b) < n) r = b + 1;
    end
    return r;
  endfunction

  // Edges from the start-sampling edge until done is visible high.
  function automatic int sort_cycles(input int depth);
    int total;
    total = 2;
    for (int w = 1; w < depth; w = w * 2) begin
      total = total + depth / w + 2 * depth;
    end
    return total;
  endfunction

endpackage

// File: rtl/merge_select.sv
// Merge compare/select: picks the head of run A or run B for the next write.
// Ties resolve to A so that the sort is stable.
module merge_select
  import merge_sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] head_a_i,
  input  logic [DATA_W-1:0] head_b_i,
  input  logic              a_ok_i,
  input  logic              b_ok_i,
  output logic              take_a_o,
  output logic [DATA_W-1:0] sel_data_o
);

  // Exhausted runs never win; equal keys favour run A.
  always_comb begin
    take_a_o = a_ok_i && (!b_ok_i || (head_a_i <= head_b_i));
    if (take_a_o) begin
      sel_data_o = head_a_i;
    end else begin
      sel_data_o = head_b_i;
    end
  end

endmodule

// File: rtl/merge_sort_sequencer.sv
// Bottom-up merge-sort controller over a ping-pong pair of register-file banks.
// Optional SORT_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module merge_sort_sequencer
  import merge_sort_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] pass_idx,
  output logic              result_bank
`ifdef SORT_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  // Pointers carry one extra bit so that base+2w can reach DEPTH.
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0]     DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]     HALF_P  = PW'(DEPTH / 2);
  localparam logic [PW-1:0]     ONE_P   = PW'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [PW-1:0]     i_q, i_d;
  logic [PW-1:0]     j_q, j_d;
  logic [PW-1:0]     k_q, k_d;
  logic [PW-1:0]     base_q, base_d;
  logic [PW-1:0]     w_q, w_d;
  logic [ADDR_W-1:0] pass_q, pass_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] head_a_q, head_a_d;
  logic [DATA_W-1:0] head_b_q, head_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              result_bank_q, result_bank_d;

  logic [PW-1:0]     mid_s;
  logic [PW-1:0]     pair_end_s;
  logic              a_ok_s;
  logic              b_ok_s;
  logic              take_a_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              accept_s;

  assign mid_s      = base_q + w_q;
  assign pair_end_s = base_q + (w_q << 1);
  assign a_ok_s     = (i_q < mid_s);
  assign b_ok_s     = (j_q < pair_end_s);
  assign accept_s   = (state_q == ST_IDLE) && start;

  merge_select #(
    .DATA_W (DATA_W)
  ) u_select (
    .head_a_i   (head_a_q),
    .head_b_i   (head_b_q),
    .a_ok_i     (a_ok_s),
    .b_ok_i     (b_ok_s),
    .take_a_o   (take_a_s),
    .sel_data_o (sel_data_s)
  );

  // Next-state logic for the pass/pair/element scheduler.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    base_d        = base_q;
    w_d           = w_q;
    pass_d        = pass_q;
    rd_bank_d     = rd_bank_q;
    head_a_d      = head_a_q;
    head_b_d      = head_b_q;
    busy_d        = busy_q;
    done_d        = done_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    result_bank_d = result_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d       = ONE_P;
          pass_d    = '0;
          rd_bank_d = 1'b0;
          base_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        i_d     = base_q;
        j_d     = mid_s;
        k_d     = base_q;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        head_a_d = rd_data_a;
        head_b_d = rd_data_b;
        if (k_q == pair_end_s) begin
          if (pair_end_s == DEPTH_P) begin
            rd_bank_d = ~rd_bank_q;
            base_d    = '0;
            if (w_q == HALF_P) begin
              result_bank_d = ~rd_bank_q;
              state_d       = ST_DONE;
            end else begin
              w_d     = w_q << 1;
              pass_d  = pass_q + ONE_A;
              state_d = ST_PRIME;
            end
          end else begin
            base_d  = pair_end_s;
            state_d = ST_PRIME;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = k_q[ADDR_W-1:0];
        wr_data_d = sel_data_s;
        k_d       = k_q + ONE_P;
        if (take_a_s) begin
          i_d = i_q + ONE_P;
        end else begin
          j_d = j_q + ONE_P;
        end
        state_d = ST_CAPTURE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts a sort in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      base_q        <= '0;
      w_q           <= ONE_P;
      pass_q        <= '0;
      rd_bank_q     <= 1'b0;
      head_a_q      <= '0;
      head_b_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      result_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      base_q        <= base_d;
      w_q           <= w_d;
      pass_q        <= pass_d;
      rd_bank_q     <= rd_bank_d;
      head_a_q      <= head_a_d;
      head_b_q      <= head_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      result_bank_q <= result_bank_d;
    end
  end

  // Read ports see the next pointers so the synchronous banks return the
  // new heads in the following CAPTURE cycle.
  assign rd_addr_a   = i_d[ADDR_W-1:0];
  assign rd_addr_b   = j_d[ADDR_W-1:0];
  assign rd_bank     = rd_bank_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign pass_idx    = pass_q;
  assign result_bank = result_bank_q;

`ifdef SORT_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Busy-cycle counter: cleared on accept, saturating, frozen once idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q <= 16'd0;
    end else if (accept_s) begin
      cyc_q <= 16'd0;
    end else if (busy_q && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end else begin
      cyc_q <= cyc_q;
    end
  end

  assign cycle_count = cyc_q;
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

endmodule

// File: doc/merge_sort_sequencer.md
Name: merge_sort_sequencer

Overview:
- Bottom-up merge-sort controller for a ping-pong pair of DEPTH-entry register-file banks.
- Runs log2(DEPTH) merge passes with run width w = 1, 2, 4 … DEPTH/2.
- Each pass reads runs from the source bank, merges each run pair and writes the result to the other bank.
- Owns all bank addressing, the compare/select datapath, pass scheduling and the done flag. It sits between the top-level start/done handshake and the memory banks.

Parameters:
- DATA_W, 16, element width; compares are unsigned.
- DEPTH, 32, element count; power of two, ≥2. ADDR_W = log2(DEPTH) is a derived localparam.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  level; set when the sort completes, cleared by the next accepted start or by reset.
- rd_bank  out  1  source bank select for both read ports.
- rd_addr_a  out  ADDR_W  read address, head of run A.
- rd_addr_b  out  ADDR_W  read address, head of run B.
- rd_data_a  in  DATA_W  data for rd_addr_a; valid one cycle after the address.
- rd_data_b  in  DATA_W  data for rd_addr_b; valid one cycle after the address.
- wr_en  out  1  write strobe into bank ~rd_bank.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- pass_idx  out  ADDR_W  current pass number, 0 … log2(DEPTH)-1.
- result_bank  out  1  bank holding sorted data; valid while done=1.

Behaviour:
- Reset values: busy=0, done=0, wr_en=0, rd_bank=0, all addresses 0, pass_idx=0, result_bank=0. FSM goes to IDLE.
- Reset mid-operation aborts immediately. No further writes occur. Bank contents are undefined.
- FSM states: IDLE, PRIME, CAPTURE, WRITE, DONE.
- IDLE, start=1: w:=1, pass_idx:=0, rd_bank:=0, pair base:=0, go to PRIME.
- PRIME: i:=base, j:=base+w, k:=base. Drive rd_addr_a=i, rd_addr_b=j. Go to CAPTURE.
- CAPTURE: latch rd_data_a/b into head registers. If k = base+2w (pair finished), go to PRIME for the next pair, or end the pass. Otherwise go to WRITE.
- WRITE: compute a_ok = i<base+w and b_ok = j<base+2w.
  - Select A if a_ok and (!b_ok or head_a ≤ head_b); ties take A, so the sort is stable. Otherwise select B.
  - wr_en=1, wr_addr=k, wr_data=selected head. Increment k and the selected pointer, then present the updated i/j on the read ports.
  - Go to CAPTURE.
- An exhausted run's head is ignored. Reads past a run's end are don't-care and are never written.
- End of pass:
  - Toggle rd_bank and set base:=0.
  - If w = DEPTH/2, go to DONE with result_bank = the last destination bank.
  - Else w:=2w, pass_idx+1, go to PRIME.
- DONE: done:=1, busy:=0, go to IDLE. done stays high in IDLE until the next accepted start clears it.
- Timing is data-independent.
  - Cost per pair of length 2w: 2+4w cycles.
  - Cost per pass: DEPTH/w + 2·DEPTH cycles.
  - Total from the start-sampling edge to the edge where done rises = 2 + Σ passes.
  - DEPTH=32 gives 384 cycles.
- Source bank of pass p is bank p%2. result_bank = log2(DEPTH)%2.
- start while busy is ignored with no effect. start=1 in the same cycle as reset release is not sampled.

Optional Feature:
- Macro SORT_CYCLE_COUNT_EN.
- Defined: adds output cycle_count [15:0]. Cleared on an accepted start, increments every cycle busy=1, saturates at 0xFFFF, holds while done=1. Reset value 0.
- Undefined: the port and counter are absent. No other behaviour changes.

Decomposition:
- Shared package merge_sort_pkg holds:
  - FSM state enum.
  - DATA_W/DEPTH defaults.
  - Function clog2.
  - Cycle-count formula function, used by the bench.
- One natural sub-module, merge_select: combinational compare of the two heads with a_ok/b_ok, producing take_a and the selected data. Everything else is inline.

Test Plan:
- Bank0 = 31,30 … 0, pulse start → bank1 = 0 … 31 ascending; result_bank=1; done rises exactly 384 cycles after start is sampled; 32·5 = 160 wr_en pulses total.
- Already-sorted 0 … 31 → same 384 cycles, bank1 ascending; data-independent timing confirmed.
- All 32 entries = 0x00AA plus a duplicate-key pattern → output matches a reference sort; on every tie the write comes from the A-run address.
- start pulsed again at cycle 100 while busy → ignored; completion still at 384; no extra writes.
- reset asserted during pass_idx=2 → next cycle wr_en=0, busy=0, done=0; a new start then completes correctly in 384 cycles.
- DEPTH=2 with data {5,3} → one pass, bank1 = {3,5}, done after 8 cycles. With SORT_CYCLE_COUNT_EN defined, cycle_count equals the measured busy cycles.
